display_scan_ctrl: RTL

//   Time-multiplexed scan controller for the Nexys A7 8-digit common-anode display.

---
 rtl/display_scan_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed BCD scan controller for a common-anode 7-segment display
module display_scan_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lz_en,
    output logic [3:0]            bcd_out,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  dp_n,
    output logic                  frame_start
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [IW-1:0]         r_idx, w_idx_nxt;
    logic [4*N_DIGITS-1:0] r_act_dig, r_pend_dig;
    logic [N_DIGITS-1:0]   r_act_dp, r_pend_dp, w_sup, w_an;
    logic                  r_act_lz, r_pend_lz, r_pend_full;
    logic                  w_boundary, w_accept, w_slot_end, w_zero_run;
    logic [3:0]            w_digit;

    // The boundary is the first BLANK cycle of digit 0; frames swap only here.
    assign w_boundary = (r_state == BLANK) && (r_cnt == '0) && (r_idx == '0);
    assign w_accept   = load_valid && !r_pend_full;
    assign load_ready = !r_pend_full;
    assign w_digit    = r_act_dig[{r_idx, 2'b00} +: 4];

    // Scan state, slot counter and digit index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state: BLANK for the guard period, SHOW for the rest of the slot, then advance digit
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_slot_end  = r_cnt == CW'(REFRESH_DIV - 1);
        w_cnt_nxt   = w_slot_end ? '0 : r_cnt + 1'b1;
        if (r_state == BLANK && r_cnt == CW'(BLANK_CYCLES - 1))
            w_state_nxt = SHOW;
        if (r_state == SHOW && w_slot_end) begin
            w_state_nxt = BLANK;
            w_idx_nxt   = r_idx == IW'(N_DIGITS - 1) ? '0 : r_idx + 1'b1;
        end
    end

    // Pending buffer captures on handshake; active frame loads from it only at a boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_full <= 1'b0;
            r_pend_dig  <= '0;
            r_pend_dp   <= '0;
            r_pend_lz   <= 1'b0;
            r_act_dig   <= '0;
            r_act_dp    <= '0;
            r_act_lz    <= 1'b0;
        end else begin
            r_pend_full <= w_accept || (r_pend_full && !w_boundary);
            if (w_accept) begin
                r_pend_dig <= digits_in;
                r_pend_dp  <= dp_in;
                r_pend_lz  <= lz_en;
            end
            if (w_boundary && r_pend_full) begin
                r_act_dig <= r_pend_dig;
                r_act_dp  <= r_pend_dp;
                r_act_lz  <= r_pend_lz;
            end
        end
    end

    // Leading-zero mask: walk down from the top digit while digits stay zero; digit 0 never blanks
    always_comb begin
        w_sup      = '0;
        w_zero_run = r_act_lz;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            w_zero_run = w_zero_run && (r_act_dig[4*i +: 4] == 4'd0);
            w_sup[i]   = w_zero_run;
        end
    end

    // One-hot active-low anode for the current index
    always_comb begin
        w_an        = '1;
        w_an[r_idx] = 1'b0;
    end

    // Registered display outputs, driven from the current scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n        <= '1;
            bcd_out     <= 4'hF;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_boundary;
            an_n        <= r_state == SHOW ? w_an : '1;
            bcd_out     <= (r_state == SHOW && !w_sup[r_idx]) ? w_digit : 4'hF;
            dp_n        <= r_state == SHOW ? ~r_act_dp[r_idx] : 1'b1;
        end
    end
endmodule
